// File: rtl/buffer_caminho_saida.sv
// buffer_caminho_saida: LIFO that captures a backtracked path (destination first) and replays it source-first on a valid/ready stream; optional comprimento_out under CAMINHO_COMPRIMENTO_EN
module buffer_caminho_saida #(
  parameter int ADDR_WIDTH = 10,
  parameter int PROF_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio_in,
  input  logic [ADDR_WIDTH-1:0] no_in,
  input  logic                  no_valido_in,
  input  logic                  fim_in,
  output logic [ADDR_WIDTH-1:0] caminho_data_out,
  output logic                  caminho_valid_out,
  input  logic                  caminho_ready_in,
  output logic                  caminho_ultimo_out,
  output logic                  ocupado_out,
  output logic                  concluido_out,
  output logic                  erro_out
`ifdef CAMINHO_COMPRIMENTO_EN
  ,
  output logic [PROF_WIDTH:0]   comprimento_out
`endif
);
  typedef enum logic [1:0] {OCIOSO, CAPTURA, ENVIO} estado_t;
  localparam logic [PROF_WIDTH:0] UM = (PROF_WIDTH+1)'(1);
  localparam logic [PROF_WIDTH:0] DOIS = (PROF_WIDTH+1)'(2);
  localparam logic [PROF_WIDTH-1:0] I1 = PROF_WIDTH'(1);
  localparam logic [PROF_WIDTH-1:0] I2 = PROF_WIDTH'(2);
  estado_t estado, prox;
  logic [ADDR_WIDTH-1:0] mem [2**PROF_WIDTH];
  logic [PROF_WIDTH:0] ptr, ptr_push, ptr_m1;
  logic [PROF_WIDTH-1:0] idx1, idx2;
  logic push, ovf, hs, fecha;
  // ptr MSB set means the stack is full (ptr == depth)
  assign push = estado == CAPTURA && no_valido_in && !ptr[PROF_WIDTH];
  assign ovf = estado == CAPTURA && no_valido_in && ptr[PROF_WIDTH];
  assign ptr_push = ptr + {{PROF_WIDTH{1'b0}}, push};
  assign ptr_m1 = ptr - UM;
  assign idx1 = ptr[PROF_WIDTH-1:0] - I1;
  assign idx2 = ptr[PROF_WIDTH-1:0] - I2;
  assign hs = caminho_valid_out && caminho_ready_in;
  assign fecha = !ovf && fim_in && ptr_push != '0;
  assign ocupado_out = estado != OCIOSO;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= OCIOSO;
    else estado <= prox;
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  prox = inicio_in ? CAPTURA : OCIOSO;
      CAPTURA: prox = ovf ? OCIOSO : fim_in ? (ptr_push != '0 ? ENVIO : OCIOSO) : CAPTURA;
      ENVIO:   prox = (hs && ptr == UM) ? OCIOSO : ENVIO;
      default: prox = OCIOSO;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[ptr[PROF_WIDTH-1:0]] <= no_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      caminho_data_out <= '0;
      caminho_valid_out <= 1'b0;
      caminho_ultimo_out <= 1'b0;
      concluido_out <= 1'b0;
      erro_out <= 1'b0;
    end else begin
      concluido_out <= 1'b0;
      case (estado)
        OCIOSO: if (inicio_in) begin
          ptr <= '0;
          erro_out <= 1'b0;
        end
        CAPTURA: begin
          ptr <= ptr_push;
          if (ovf) erro_out <= 1'b1;
          else if (fecha) begin
            // the top-of-stack node may be the one being pushed on this very edge
            caminho_data_out <= push ? no_in : mem[idx1];
            caminho_valid_out <= 1'b1;
            caminho_ultimo_out <= ptr_push == UM;
          end else if (fim_in) concluido_out <= 1'b1;
        end
        ENVIO: if (hs) begin
          ptr <= ptr_m1;
          if (ptr > UM) begin
            caminho_data_out <= mem[idx2];
            caminho_ultimo_out <= ptr == DOIS;
          end else begin
            caminho_valid_out <= 1'b0;
            caminho_ultimo_out <= 1'b0;
            concluido_out <= 1'b1;
          end
        end
        default: ptr <= '0;
      endcase
    end
`ifdef CAMINHO_COMPRIMENTO_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) comprimento_out <= '0;
    else if (estado == OCIOSO && inicio_in) comprimento_out <= '0;
    else if (ovf) comprimento_out <= '0;
    else if (estado == CAPTURA && fecha) comprimento_out <= ptr_push;
`endif
endmodule
